// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN       : architectural register / address width
//   NOP_INSTR  : canonical RISC-V NOP (addi x0, x0, 0)
//   fetch_slot_t : one slot of the fetch buffer {pc, instr, filled, misalign}
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
        logic            misalign;
    } fetch_slot_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its neighbours (PC register, instruction
// memory, decode).
//   master : fetch unit side (drives pc_advance, imem_req_*, if_valid/pc/instr/misalign)
//   slave  : environment side (drives pc_in, flush, imem_req_ready, imem_rsp_*, if_ready)
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [XLEN-1:0] pc_in;
    logic            pc_advance;
    logic            flush;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            if_misalign;

    modport master (
        input  pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output pc_advance, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
               if_misalign
    );

    modport slave (
        output pc_in, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  pc_advance, imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
               if_misalign
    );

endinterface

// File: rtl/instr_fetch_unit_slot_buffer.sv
// Circular slot buffer pairing each fetched PC with its instruction word.
//   clk, reset            : clock, async active-low reset
//   i_flush               : drop every slot and rewind all pointers
//   i_alloc/_pc/_misalign : claim slot[alloc] for a new PC (misaligned slots arrive filled)
//   i_fill/_instr         : write returned instruction into slot[fill]
//   i_fire                : decode consumed slot[rd]
//   o_count               : slots in use (alloc - rd)
//   o_outstanding         : slots awaiting memory data (alloc - fill)
//   o_head/_valid         : slot[rd] and whether it is ready for decode
module instr_fetch_unit_slot_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_alloc,
    input  logic [XLEN-1:0] i_alloc_pc,
    input  logic            i_alloc_misalign,
    input  logic            i_fill,
    input  logic [XLEN-1:0] i_fill_instr,
    input  logic            i_fire,
    output logic [AW:0]     o_count,
    output logic [AW:0]     o_outstanding,
    output logic            o_head_valid,
    output fetch_slot_t     o_head
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    fetch_slot_t r_slots [DEPTH];
    logic [AW:0] r_alloc_ptr;
    logic [AW:0] r_fill_ptr;
    logic [AW:0] r_rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0, misalign: 1'b0};
            end
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_slots[r_alloc_ptr[AW-1:0]] <= '{pc: i_alloc_pc, instr: NOP_INSTR,
                                                  filled: i_alloc_misalign,
                                                  misalign: i_alloc_misalign};
                r_alloc_ptr <= r_alloc_ptr + PTR_ONE;
            end
            if (i_fill) begin
                r_slots[r_fill_ptr[AW-1:0]].instr  <= i_fill_instr;
                r_slots[r_fill_ptr[AW-1:0]].filled <= 1'b1;
            end
            // Misaligned inserts only happen with nothing outstanding, so fill steps past
            // them together with alloc and keeps pointing at the oldest unfilled slot.
            if (i_fill || (i_alloc && i_alloc_misalign)) begin
                r_fill_ptr <= r_fill_ptr + PTR_ONE;
            end
            if (i_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        o_count       = r_alloc_ptr - r_rd_ptr;
        o_outstanding = r_alloc_ptr - r_fill_ptr;
        o_head        = r_slots[r_rd_ptr[AW-1:0]];
        o_head_valid  = o_head.filled && (r_rd_ptr != r_alloc_ptr);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order instruction memory reads for pc_in, buffers
// {pc, instr} pairs and hands them to decode over valid/ready.
//   clk, reset : clock, async active-low reset
//   fetch_if   : master side of instr_fetch_unit_if (PC, imem request/response, decode)
// Parameters: DEPTH slots (power of 2, >= 2); RESET_PC shown on if_pc while idle.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned    AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master fetch_if
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0] w_count;
    logic [AW:0] w_outstanding;
    logic [AW:0] r_drop_cnt;
    logic [AW:0] w_drop_d;
    logic        w_space;
    logic        w_aligned;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_mis_ins;
    logic        w_fill;
    logic        w_rsp_taken;
    logic        w_head_valid;
    logic        w_if_valid;
    logic        w_fire;
    fetch_slot_t w_head;

    always_comb begin
        // Gating with reset keeps request/advance low while reset is held.
        w_space     = reset && (w_count < FULL_CNT);
        w_aligned   = (fetch_if.pc_in[1:0] == 2'b00);
        w_req_valid = w_space && !fetch_if.flush && w_aligned;
        w_accept    = w_req_valid && fetch_if.imem_req_ready;
        // A misaligned PC waits until every earlier fetch has returned, keeping order.
        w_mis_ins   = w_space && !fetch_if.flush && !w_aligned && (w_outstanding == '0);
        w_fill      = fetch_if.imem_rsp_valid && (r_drop_cnt == '0) && (w_outstanding != '0)
                      && !fetch_if.flush;
        w_if_valid  = w_head_valid && !fetch_if.flush;
        w_fire      = w_if_valid && fetch_if.if_ready;

        // Each legal response retires one memory transaction, dropped or live.
        w_rsp_taken = fetch_if.imem_rsp_valid && ((r_drop_cnt != '0) || (w_outstanding != '0));
        w_drop_d    = r_drop_cnt;
        if (fetch_if.flush) begin
            w_drop_d = r_drop_cnt + w_outstanding - {{AW{1'b0}}, w_rsp_taken};
        end else if (fetch_if.imem_rsp_valid && (r_drop_cnt != '0)) begin
            w_drop_d = r_drop_cnt - (AW+1)'(1);
        end

        fetch_if.imem_req_valid = w_req_valid;
        fetch_if.imem_req_addr  = {fetch_if.pc_in[XLEN-1:2], 2'b00};
        fetch_if.pc_advance     = w_accept || w_mis_ins;
        fetch_if.if_valid       = w_if_valid;
        fetch_if.if_pc          = w_if_valid ? w_head.pc : RESET_PC;
        fetch_if.if_instr       = w_if_valid ? w_head.instr : NOP_INSTR;
        fetch_if.if_misalign    = w_if_valid && w_head.misalign;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_d;
        end
    end

    instr_fetch_unit_slot_buffer #(
        .DEPTH (DEPTH)
    ) u_slot_buffer (
        .clk              (clk),
        .reset            (reset),
        .i_flush          (fetch_if.flush),
        .i_alloc          (fetch_if.pc_advance),
        .i_alloc_pc       (fetch_if.pc_in),
        .i_alloc_misalign (w_mis_ins),
        .i_fill           (w_fill),
        .i_fill_instr     (fetch_if.imem_rsp_data),
        .i_fire           (w_fire),
        .o_count          (w_count),
        .o_outstanding    (w_outstanding),
        .o_head_valid     (w_head_valid),
        .o_head           (w_head)
    );

    // A response with nothing outstanding and nothing to drop breaks the memory protocol.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        fetch_if.imem_rsp_valid |-> ((r_drop_cnt != '0) || (w_outstanding != '0)));

    a_drop_bounded: assert property (@(posedge clk) disable iff (!reset)
        r_drop_cnt <= FULL_CNT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random
// traffic, all compared against an in-order queue model of slots and memory.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic reset;
    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .fetch_if (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          mis;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    ent_t  mq[$];    // entries held by the fetch unit, oldest first
    mreq_t memq[$];  // reads accepted by memory, not yet answered

    int n_checks = 0;
    int n_fail   = 0;

    int p_flush, p_ready, p_if_ready, p_rsp, p_mis, p_jmp;
    bit cur_flush, cur_ready, cur_if_ready, cur_rsp;
    bit exp_req_valid, exp_mis, exp_adv, exp_if_valid;
    logic [31:0] pc_cur;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        int r;
        logic [31:0] tmp;
        r   = $urandom_range(0, 99);
        tmp = $urandom;
        if (r < p_mis) return {tmp[31:2], 2'($urandom_range(1, 3))};
        if (r < p_mis + p_jmp) return tmp & 32'hFFFF_FFFC;
        return pc + 32'd4;
    endfunction

    task automatic set_knobs(input int fl, input int rdy, input int ifr, input int rsp,
                             input int mis, input int jmp);
        p_flush = fl; p_ready = rdy; p_if_ready = ifr; p_rsp = rsp; p_mis = mis; p_jmp = jmp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, bus.imem_req_valid, 0);
        check_eq({tag, "_pc_advance"}, bus.pc_advance, 0);
        check_eq({tag, "_if_valid"}, bus.if_valid, 0);
        check_eq({tag, "_if_pc"}, bus.if_pc, RST_PC);
        check_eq({tag, "_if_instr"}, bus.if_instr, NOP_INSTR);
        check_eq({tag, "_if_misalign"}, bus.if_misalign, 0);
    endtask

    // Drive one cycle of inputs, then compare outputs against the model at the negedge.
    task automatic step_begin();
        int n_out;
        cur_flush    = roll(p_flush);
        cur_ready    = (memq.size() < DEPTH) && roll(p_ready);
        cur_if_ready = roll(p_if_ready);
        cur_rsp      = (memq.size() > 0) && roll(p_rsp);
        bus.pc_in          = pc_cur;
        bus.flush          = cur_flush;
        bus.imem_req_ready = cur_ready;
        bus.imem_rsp_valid = cur_rsp;
        bus.imem_rsp_data  = cur_rsp ? mem_word(memq[0].addr) : $urandom;
        bus.if_ready       = cur_if_ready;
        #4;
        n_out = 0;
        foreach (mq[i]) if (!mq[i].filled) n_out++;
        exp_req_valid = (mq.size() < DEPTH) && !cur_flush && (pc_cur[1:0] == 2'b00);
        exp_mis       = (mq.size() < DEPTH) && !cur_flush && (pc_cur[1:0] != 2'b00)
                        && (n_out == 0);
        exp_adv       = (exp_req_valid && cur_ready) || exp_mis;
        exp_if_valid  = !cur_flush && (mq.size() > 0) && mq[0].filled;
        check_eq("req_valid", bus.imem_req_valid, exp_req_valid);
        check_eq("pc_advance", bus.pc_advance, exp_adv);
        check_eq("if_valid", bus.if_valid, exp_if_valid);
        if (exp_req_valid) check_eq("req_addr", bus.imem_req_addr, pc_cur & 32'hFFFF_FFFC);
        if (exp_if_valid) begin
            check_eq("if_pc", bus.if_pc, mq[0].pc);
            check_eq("if_instr", bus.if_instr, mq[0].instr);
            check_eq("if_misalign", bus.if_misalign, mq[0].mis);
        end else begin
            check_eq("idle_pc", bus.if_pc, RST_PC);
        end
    endtask

    // Advance the model across the clock edge.
    task automatic step_end();
        mreq_t m;
        @(posedge clk);
        if (cur_rsp) begin
            m = memq.pop_front();
            if (m.live && !cur_flush) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].filled) begin
                        mq[i].instr  = mem_word(m.addr);
                        mq[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (cur_flush) begin
            foreach (memq[i]) memq[i].live = 1'b0;
            mq.delete();
        end else begin
            if (exp_if_valid && cur_if_ready) void'(mq.pop_front());
            if (exp_req_valid && cur_ready) begin
                mq.push_back('{pc: pc_cur, instr: NOP_INSTR, mis: 1'b0, filled: 1'b0});
                memq.push_back('{addr: pc_cur & 32'hFFFF_FFFC, live: 1'b1});
            end
            if (exp_mis) mq.push_back('{pc: pc_cur, instr: NOP_INSTR, mis: 1'b1, filled: 1'b1});
        end
        if (exp_adv) pc_cur = next_pc(pc_cur);
        if (cur_flush && p_jmp > 0) pc_cur = $urandom & 32'hFFFF_FFFC;
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step_begin();
            step_end();
        end
    endtask

    task automatic drain();
        set_knobs(0, 0, 100, 100, 0, 0);
        run(10);
    endtask

    // Run until decode sees an entry, then check it against fixed values.
    task automatic expect_first(input string tag, input logic [31:0] pc,
                                input logic [31:0] instr, input logic mis);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            step_begin();
            if (bus.if_valid) begin
                seen = 1'b1;
                check_eq({tag, "_pc"}, bus.if_pc, pc);
                check_eq({tag, "_instr"}, bus.if_instr, instr);
                check_eq({tag, "_mis"}, bus.if_misalign, mis);
            end
            step_end();
        end
        check_eq({tag, "_seen"}, seen, 1);
    endtask

    initial begin
        reset = 1'b0;
        pc_cur = 32'h0;
        bus.pc_in = 32'h0; bus.flush = 1'b0; bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0; bus.if_ready = 1'b1;
        #3;
        check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Basic fetch from 0, then 4, 8 in order.
        set_knobs(0, 100, 100, 100, 0, 0);
        step_begin();
        check_eq("t1_addr", bus.imem_req_addr, 32'h0);
        check_eq("t1_adv", bus.pc_advance, 1);
        step_end();
        expect_first("t1", 32'h0, 32'h0050_0093, 1'b0);
        run(6);

        // Fill all slots with decode stalled.
        set_knobs(0, 100, 0, 100, 0, 0);
        run(10);
        p_if_ready = 100;
        step_begin();
        check_eq("t2_full_req", bus.imem_req_valid, 0);
        check_eq("t2_full_adv", bus.pc_advance, 0);
        step_end();
        p_if_ready = 0;
        step_begin();
        check_eq("t2_resume", bus.imem_req_valid, 1);
        step_end();

        // Flush with two fetches outstanding and one filled entry waiting.
        drain();
        set_knobs(0, 100, 0, 0, 0, 0);
        run(3);
        set_knobs(0, 0, 0, 100, 0, 0);
        run(1);
        set_knobs(100, 0, 0, 0, 0, 0);
        step_begin();
        check_eq("t3_flush_valid", bus.if_valid, 0);
        step_end();
        pc_cur = 32'h100;
        set_knobs(0, 100, 100, 100, 0, 0);
        expect_first("t3", 32'h100, mem_word(32'h100), 1'b0);

        // Flush coinciding with a response, one other fetch outstanding.
        drain();
        set_knobs(0, 100, 0, 0, 0, 0);
        run(2);
        set_knobs(100, 0, 0, 100, 0, 0);
        run(1);
        pc_cur = 32'h300;
        set_knobs(0, 100, 100, 100, 0, 0);
        expect_first("t4", 32'h300, mem_word(32'h300), 1'b0);

        // Misaligned PC becomes a NOP entry without a memory request.
        drain();
        pc_cur = 32'h6;
        set_knobs(0, 100, 100, 100, 0, 0);
        step_begin();
        check_eq("t5_no_req", bus.imem_req_valid, 0);
        check_eq("t5_adv", bus.pc_advance, 1);
        step_end();
        pc_cur = 32'h200;
        expect_first("t5", 32'h6, NOP_INSTR, 1'b1);

        // Random traffic, then an asynchronous reset mid-burst.
        set_knobs(6, 70, 70, 60, 8, 8);
        run(400);
        step_begin();
        #2;
        reset = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        check_reset_outputs("t6");
        mq.delete();
        memq.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        pc_cur = 32'h40;
        set_knobs(0, 100, 100, 100, 0, 0);
        expect_first("t6_after", 32'h40, mem_word(32'h40), 1'b0);

        set_knobs(6, 70, 70, 60, 8, 8);
        run(1500);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
